// File: rtl/wasm_core_if.sv
// Byte-stream and result/status bundle between a bytecode source and wasm_core.
interface wasm_core_if #(
    parameter int DEPTH_W = 5
);
    logic               in_valid;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic [63:0]        result;
    logic [1:0]         result_type;
    logic               result_empty;
    logic               result_valid;
    logic [2:0]         trap;
    logic [DEPTH_W-1:0] depth;

    modport master (
        output in_valid, in_byte,
        input  in_ready, result, result_type, result_empty, result_valid, trap, depth
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, result, result_type, result_empty, result_valid, trap, depth
    );
endinterface

// File: rtl/wasm_core.sv
// Tiny WebAssembly subset interpreter: byte-serial fetch, LEB128 immediates, typed operand stack.
// Define WASM_CORE_I64_EN to add i64.const, i64.eqz and i64.add/sub (10-byte immediates).
module wasm_core #(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic        clk,
    input  logic        reset,
    wasm_core_if.slave  bus
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [1:0] T_I32 = 2'd0;
`ifdef WASM_CORE_I64_EN
    localparam logic [1:0] T_I64 = 2'd1;
`endif

    typedef enum logic [1:0] {FETCH, IMM, EXEC, HALT} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         opcode_reg, opcode_next;
    logic [63:0]        imm_reg, imm_next;
    logic [3:0]         imm_cnt_reg, imm_cnt_next;
    logic [2:0]         trap_reg, trap_next;
    logic [DEPTH_W-1:0] depth_reg;
    logic [63:0]        result_reg;
    logic [1:0]         result_type_reg;
    logic               result_empty_reg, result_valid_reg, ready_en_reg;
    logic [65:0]        stack_mem [STACK_DEPTH];

    logic               accept, is_imm_op;
    logic [6:0]         shift_amt, sign_shift;
    logic [63:0]        imm_acc, sign_mask;
    logic [3:0]         imm_last;
    logic [AW-1:0]      idx1, idx2, idx3, wr_idx;
    logic [65:0]        tos, nos, third, push_val;
    logic [DEPTH_W-1:0] need, pop_n;
    logic               push_en, grow, type_err, is_end, commit;
    logic [2:0]         op_trap, exec_trap;
    logic [31:0]        alu32;

    assign accept    = bus.in_valid && bus.in_ready;
`ifdef WASM_CORE_I64_EN
    assign is_imm_op = (bus.in_byte == 8'h41) || (bus.in_byte == 8'h42);
`else
    assign is_imm_op = (bus.in_byte == 8'h41);
`endif

    // Each LEB128 byte contributes 7 bits; the terminating byte's bit6 fills everything above it.
    assign shift_amt  = 7'(imm_cnt_reg) * 7'd7;
    assign sign_shift = shift_amt + 7'd7;
    assign imm_acc    = imm_reg | ({57'd0, bus.in_byte[6:0]} << shift_amt);
    assign sign_mask  = ~((64'd1 << sign_shift) - 64'd1);
    assign imm_last   = (opcode_reg == 8'h42) ? 4'd9 : 4'd4;

    assign idx1   = AW'(depth_reg - DEPTH_W'(1));
    assign idx2   = AW'(depth_reg - DEPTH_W'(2));
    assign idx3   = AW'(depth_reg - DEPTH_W'(3));
    assign tos    = stack_mem[idx1];
    assign nos    = stack_mem[idx2];
    assign third  = stack_mem[idx3];
    assign wr_idx = AW'(depth_reg - pop_n);
    assign alu32  = opcode_reg[0] ? (nos[31:0] - tos[31:0]) : (nos[31:0] + tos[31:0]);
`ifdef WASM_CORE_I64_EN
    logic [63:0] alu64;
    assign alu64  = opcode_reg[0] ? (nos[63:0] - tos[63:0]) : (nos[63:0] + tos[63:0]);
`endif

    always_comb begin
        op_trap  = 3'd0;
        need     = '0;
        pop_n    = '0;
        push_en  = 1'b0;
        push_val = '0;
        grow     = 1'b0;
        type_err = 1'b0;
        is_end   = 1'b0;
        case (opcode_reg)
            8'h00: op_trap = 3'd3;
            8'h01: ;
            8'h0B: is_end = 1'b1;
            8'h1A: begin need = DEPTH_W'(1); pop_n = DEPTH_W'(1); end
            8'h1B: begin
                need     = DEPTH_W'(3);
                pop_n    = DEPTH_W'(3);
                push_en  = 1'b1;
                type_err = (tos[65:64] != T_I32) || (nos[65:64] != third[65:64]);
                push_val = (tos[31:0] != 32'd0) ? third : nos;
            end
            8'h41: begin grow = 1'b1; push_en = 1'b1; push_val = {T_I32, 32'd0, imm_reg[31:0]}; end
            8'h45: begin
                need     = DEPTH_W'(1);
                pop_n    = DEPTH_W'(1);
                push_en  = 1'b1;
                type_err = (tos[65:64] != T_I32);
                push_val = {T_I32, 63'd0, tos[31:0] == 32'd0};
            end
            8'h6A, 8'h6B: begin
                need     = DEPTH_W'(2);
                pop_n    = DEPTH_W'(2);
                push_en  = 1'b1;
                type_err = (tos[65:64] != T_I32) || (nos[65:64] != T_I32);
                push_val = {T_I32, 32'd0, alu32};
            end
`ifdef WASM_CORE_I64_EN
            8'h42: begin grow = 1'b1; push_en = 1'b1; push_val = {T_I64, imm_reg}; end
            8'h50: begin
                need     = DEPTH_W'(1);
                pop_n    = DEPTH_W'(1);
                push_en  = 1'b1;
                type_err = (tos[65:64] != T_I64);
                push_val = {T_I32, 63'd0, tos[63:0] == 64'd0};
            end
            8'h7C, 8'h7D: begin
                need     = DEPTH_W'(2);
                pop_n    = DEPTH_W'(2);
                push_en  = 1'b1;
                type_err = (tos[65:64] != T_I64) || (nos[65:64] != T_I64);
                push_val = {T_I64, alu64};
            end
`endif
            default: op_trap = 3'd4;
        endcase
        // Underflow outranks overflow, which outranks a type mismatch.
        if (depth_reg < need)                exec_trap = 3'd2;
        else if (grow && depth_reg == FULL)  exec_trap = 3'd1;
        else if (type_err)                   exec_trap = 3'd6;
        else                                 exec_trap = op_trap;
    end

    assign commit = (state_reg == EXEC) && (exec_trap == 3'd0);

    always_comb begin
        state_next   = state_reg;
        opcode_next  = opcode_reg;
        imm_next     = imm_reg;
        imm_cnt_next = imm_cnt_reg;
        trap_next    = trap_reg;
        case (state_reg)
            FETCH: if (accept) begin
                opcode_next  = bus.in_byte;
                imm_next     = '0;
                imm_cnt_next = '0;
                state_next   = is_imm_op ? IMM : EXEC;
            end
            IMM: if (accept) begin
                imm_next     = imm_acc;
                imm_cnt_next = imm_cnt_reg + 4'd1;
                if (!bus.in_byte[7]) begin
                    if (bus.in_byte[6]) imm_next = imm_acc | sign_mask;
                    state_next = EXEC;
                end else if (imm_cnt_reg == imm_last) begin
                    trap_next  = 3'd5;
                    state_next = HALT;
                end
            end
            EXEC: begin
                if (exec_trap != 3'd0) begin
                    trap_next  = exec_trap;
                    state_next = HALT;
                end else begin
                    state_next = FETCH;
                end
            end
            HALT: ;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= FETCH;
            opcode_reg       <= '0;
            imm_reg          <= '0;
            imm_cnt_reg      <= '0;
            trap_reg         <= '0;
            depth_reg        <= '0;
            result_reg       <= '0;
            result_type_reg  <= '0;
            result_empty_reg <= 1'b1;
            result_valid_reg <= 1'b0;
            ready_en_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            opcode_reg       <= opcode_next;
            imm_reg          <= imm_next;
            imm_cnt_reg      <= imm_cnt_next;
            trap_reg         <= trap_next;
            ready_en_reg     <= 1'b1;
            result_valid_reg <= 1'b0;
            if (commit) begin
                depth_reg <= depth_reg - pop_n + DEPTH_W'(push_en);
                if (is_end) begin
                    result_valid_reg <= 1'b1;
                    result_empty_reg <= (depth_reg == '0);
                    result_reg       <= (depth_reg == '0) ? 64'd0 : tos[63:0];
                    result_type_reg  <= (depth_reg == '0) ? T_I32 : tos[65:64];
                end
            end
        end
    end

    // Stack contents need no reset: depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (commit && push_en) stack_mem[wr_idx] <= push_val;
    end

    assign bus.in_ready     = ready_en_reg && ((state_reg == FETCH) || (state_reg == IMM));
    assign bus.result       = result_reg;
    assign bus.result_type  = result_type_reg;
    assign bus.result_empty = result_empty_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.trap         = trap_reg;
    assign bus.depth        = depth_reg;
endmodule

// File: doc/wasm_core.md
WASM_CORE -- requirements
Module: wasm_core

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, giving the operand stack entries (2..256).
REQ-002 SHALL have parameter DEPTH_W, default 5, giving the width of depth; it SHALL be ≥ clog2(STACK_DEPTH+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_byte holds a bytecode byte.
REQ-006 SHALL have port in_byte, input, 8 bits: opcode or immediate byte.
REQ-007 SHALL have port in_ready, output, 1 bit: the core accepts in_byte this cycle.
REQ-008 SHALL have port result, output, 64 bits: TOS value captured at `end`.
REQ-009 SHALL have port result_type, output, 2 bits: TOS type at `end` (i32=0, i64=1, f32=2, f64=3).
REQ-010 SHALL have port result_empty, output, 1 bit: the stack was empty at `end`.
REQ-011 SHALL have port result_valid, output, 1 bit: one-cycle pulse when result fields update.
REQ-012 SHALL have port trap, output, 3 bits: sticky trap code; 0 means running.
REQ-013 SHALL have port depth, output, DEPTH_W bits: current stack occupancy.

Function
REQ-014 A byte SHALL transfer only on a cycle where in_valid and in_ready are both 1.
REQ-015 States SHALL be FETCH, IMM, EXEC and HALT; in_ready SHALL be 1 in FETCH and IMM only.
REQ-016 FETCH: an accepted opcode SHALL go to IMM for 0x41/0x42, otherwise to EXEC.
REQ-017 EXEC SHALL last exactly one cycle, commit the stack update at its end, then return to FETCH, or go to HALT on a trap.
REQ-018 Effects of an opcode accepted in cycle N SHALL be visible on depth in cycle N+2.
REQ-019 IMM SHALL accumulate signed LEB128 7 bits per byte and leave after the byte with bit7=0.
REQ-020 IMM SHALL sign-extend from the last byte's bit6.
REQ-021 An immediate longer than 5 bytes (i32) or 10 bytes (i64) SHALL trap 5.
REQ-022 Stack entries SHALL be 66 bits as {type[1:0], value[63:0]}; i32 values SHALL be held zero-extended.
REQ-023 Opcode 0x00 unreachable SHALL trap 3.
REQ-024 Opcode 0x01 nop SHALL have no effect.
REQ-025 Opcode 0x0B end SHALL copy TOS to result/result_type, set result_empty = (depth==0), pulse result_valid, and leave the stack unchanged.
REQ-026 With depth==0, end SHALL drive result = 0 and result_type = 0.
REQ-027 Opcode 0x1A drop SHALL pop 1 entry.
REQ-028 Opcode 0x1B select SHALL pop cond, b and a, then push a if cond[31:0]≠0 else b.
REQ-029 select SHALL trap 6 if cond is not i32 or if a and b differ in type.
REQ-030 Opcode 0x41/0x42 const SHALL push the immediate as i32/i64.
REQ-031 Opcode 0x45/0x50 eqz SHALL replace TOS with i32 1 if the value is zero, else i32 0; an operand type mismatch SHALL trap 6.
REQ-032 Opcode 0x6A/0x6B i32.add/sub SHALL pop 2 and push the result mod 2^32.
REQ-033 Opcode 0x7C/0x7D i64.add/sub SHALL pop 2 and push the result mod 2^64.
REQ-034 Binary operations SHALL trap 6 on operand type mismatch.
REQ-035 A push at depth==STACK_DEPTH SHALL trap 1.
REQ-036 Popping more entries than depth SHALL trap 2.
REQ-037 Any other opcode SHALL trap 4.
REQ-038 On any trap the stack and depth SHALL remain at their pre-opcode values.
REQ-039 HALT SHALL keep in_ready=0 and trap constant until reset.
REQ-040 Trap priority SHALL be 2 > 1 > 6 when several trap conditions apply.

Reset
REQ-041 While reset=0, outputs SHALL be: result=0, result_type=0, result_empty=1, result_valid=0, trap=0, depth=0, in_ready=0.
REQ-042 While reset=0, the state SHALL be FETCH.
REQ-043 Reset asserted mid-immediate or in EXEC SHALL discard partial work and clear the stack.
REQ-044 in_ready SHALL rise on the first clk edge after reset deasserts.

Configuration
REQ-045 With macro WASM_CORE_I64_EN defined, opcodes 0x42, 0x50, 0x7C and 0x7D SHALL be supported, with 10-byte immediates.
REQ-046 With WASM_CORE_I64_EN undefined, those opcodes SHALL trap 4, and no 64-bit adder SHALL be built.

Verification
REQ-047 Bytes 41 05 41 03 6A 0B -> result_valid once; result=8, result_type=0, result_empty=0, depth=1.
REQ-048 Bytes 41 7F 45 0B -> i32.const -1 gives 0xFFFFFFFF; result=0, result_type=0.
REQ-049 Bytes 41 0A 41 14 41 00 1B 0B -> result=20, depth=1; repeated with cond 41 01 -> result=10.
REQ-050 With STACK_DEPTH=2: 41 01 41 02 41 03 -> trap=1, depth=2, in_ready stays 0; reset then 1A -> trap=2.
REQ-051 Bytes 42 80 80 80 80 80 80 80 80 80 80 -> trap=5 (with WASM_CORE_I64_EN); without the macro, byte 42 -> trap=4.
REQ-052 Reset asserted after 41 80 (incomplete immediate), then 01 0B -> result_empty=1, trap=0.
